// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mdu_ctrl
// Description : Multiply/divide controller owning HI/LO, sequencing a
//               1-cycle multiplier and an iterative start/done divider.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_ctrl #(
    parameter int DIV_TIMEOUT = 63
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_src0,
    input  logic [31:0] req_src1,
    input  logic        flush,
    output logic [31:0] mul_src0,
    output logic [31:0] mul_src1,
    output logic        mul_signed,
    input  logic [63:0] mul_res,
    output logic        div_start,
    output logic        div_signed,
    output logic [31:0] div_src0,
    output logic [31:0] div_src1,
    output logic        div_cancel,
    input  logic        div_done,
    input  logic [31:0] div_quot,
    input  logic [31:0] div_rem,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        hilo_busy,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MUL_WAIT = 2'd1,
        S_DIV_WAIT = 2'd2
    } state_t;

    localparam logic [2:0] c_OP_MULT  = 3'd0;
    localparam logic [2:0] c_OP_MULTU = 3'd1;
    localparam logic [2:0] c_OP_DIV   = 3'd2;
    localparam logic [2:0] c_OP_DIVU  = 3'd3;
    localparam logic [2:0] c_OP_MTHI  = 3'd4;
    localparam logic [2:0] c_OP_MTLO  = 3'd5;
    localparam logic [5:0] c_CNT_LAST = 6'(DIV_TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_src0;
    logic [31:0] r_src1;
    logic [2:0]  r_op;
    logic [5:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_timeout;

    logic w_accept;
    logic w_is_mul;
    logic w_is_div;
    logic w_div_start;
    logic w_div_cancel;
    logic w_wr_mul;
    logic w_wr_div;
    logic w_timeout_set;

    assign w_accept = req_valid & (r_state == S_IDLE) & ~flush;
    assign w_is_mul = (req_op == c_OP_MULT) | (req_op == c_OP_MULTU);
    assign w_is_div = (req_op == c_OP_DIV) | (req_op == c_OP_DIVU);

    always_comb begin
        w_state_next  = r_state;
        w_div_start   = 1'b0;
        w_div_cancel  = 1'b0;
        w_wr_mul      = 1'b0;
        w_wr_div      = 1'b0;
        w_timeout_set = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_is_mul) begin
                    w_state_next = S_MUL_WAIT;
                end else if (w_accept && w_is_div && (req_src1 != 32'd0)) begin
                    w_div_start  = 1'b1;
                    w_state_next = S_DIV_WAIT;
                end
            end
            S_MUL_WAIT: begin
                w_wr_mul     = ~flush;
                w_state_next = S_IDLE;
            end
            S_DIV_WAIT: begin
                // Flush outranks a coincident done; done outranks the watchdog.
                if (flush) begin
                    w_div_cancel = 1'b1;
                    w_state_next = S_IDLE;
                end else if (div_done) begin
                    w_wr_div     = 1'b1;
                    w_state_next = S_IDLE;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_div_cancel  = 1'b1;
                    w_timeout_set = 1'b1;
                    w_state_next  = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_src0    <= 32'd0;
            r_src1    <= 32'd0;
            r_op      <= 3'd0;
            r_cnt     <= 6'd0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_src0 <= req_src0;
                r_src1 <= req_src1;
                r_op   <= req_op;
            end
            // Counter numbers DIV_WAIT cycles from zero and clears on exit.
            if ((r_state == S_DIV_WAIT) && (w_state_next == S_DIV_WAIT)) begin
                r_cnt <= r_cnt + 6'd1;
            end else begin
                r_cnt <= 6'd0;
            end
            if (w_accept && (req_op == c_OP_MTHI)) begin
                r_hi <= req_src0;
            end else if (w_wr_mul) begin
                r_hi <= mul_res[63:32];
            end else if (w_wr_div) begin
                r_hi <= div_rem;
            end
            if (w_accept && (req_op == c_OP_MTLO)) begin
                r_lo <= req_src0;
            end else if (w_wr_mul) begin
                r_lo <= mul_res[31:0];
            end else if (w_wr_div) begin
                r_lo <= div_quot;
            end
            if (w_timeout_set) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign req_ready   = (r_state == S_IDLE);
    assign mul_src0    = w_accept ? req_src0 : r_src0;
    assign mul_src1    = w_accept ? req_src1 : r_src1;
    assign mul_signed  = w_accept ? (req_op == c_OP_MULT) : (r_op == c_OP_MULT);
    assign div_signed  = w_accept ? (req_op == c_OP_DIV) : (r_op == c_OP_DIV);
    assign div_src0    = r_src0;
    assign div_src1    = r_src1;
    assign div_start   = w_div_start;
    assign div_cancel  = w_div_cancel;
    assign hi          = r_hi;
    assign lo          = r_lo;
    // Ops 0-3 all have bit 2 clear: any pending mul/div blocks MFHI/MFLO.
    assign hilo_busy   = (r_state != S_IDLE) | (req_valid & ~req_op[2]);
    assign timeout_err = r_timeout;

endmodule
`default_nettype wire
